spi_target_rx: RTL

- SPI mode-0 target (slave) endpoint for the SPI transmitter in this codebase.
- Receives serial frames on SCLK/MOSI/CS from an external master, deserialises them into parallel words and presents each word with a one-cycle valid strobe.
- Simultaneously shifts a preloaded response word out on MISO.
- All SPI inputs are asynchronous to clk and are oversampled; clk must be at least 4x the SCLK frequency.

---
 rtl/spi_target_rx.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/spi_target_rx.sv
// SPI mode-0 target endpoint: oversamples SCLK/MOSI/CS, deserialises
// MOSI words and shifts a preloaded response word out on MISO.
// Ports: clk, rst (async, active high); SPI pins SCLK, MOSI, CS (low
// active), MISO; rx_data/rx_valid received word and strobe; frame_err
// strobe on CS rising mid-word; tx_data/tx_load/tx_ready response buffer.
module spi_target_rx #(
   parameter int DATA_W      = 8,
   parameter bit LSB_FIRST   = 1'b1,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SCLK,
   input  logic              MOSI,
   input  logic              CS,
   output logic              MISO,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              frame_err,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   output logic              tx_ready
);

   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic {IDLE, ACTIVE} state_t;

   // synchronisers and edge history
   logic [SYNC_STAGES-1:0] sclk_q, mosi_q, cs_q, ok_q;
   logic                   sclk_h, cs_h;
   logic                   sclk_s, mosi_s, cs_s, ok_s;
   logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

   assign sclk_s = sclk_q[SYNC_STAGES-1];
   assign mosi_s = mosi_q[SYNC_STAGES-1];
   assign cs_s   = cs_q[SYNC_STAGES-1];
   // ok_s marks that cs_s holds a real sample rather than the reset value
   assign ok_s   = ok_q[SYNC_STAGES-1];

   assign sclk_rise = sclk_s & ~sclk_h;
   assign sclk_fall = ~sclk_s & sclk_h;
   assign cs_rise   = cs_s & ~cs_h;
   assign cs_fall   = ~cs_s & cs_h;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_q <= '0;
         mosi_q <= '0;
         cs_q   <= '1;
         ok_q   <= '0;
         sclk_h <= 1'b0;
         cs_h   <= 1'b1;
      end else begin
         sclk_q <= {sclk_q[SYNC_STAGES-2:0], SCLK};
         mosi_q <= {mosi_q[SYNC_STAGES-2:0], MOSI};
         cs_q   <= {cs_q[SYNC_STAGES-2:0], CS};
         ok_q   <= {ok_q[SYNC_STAGES-2:0], 1'b1};
         sclk_h <= sclk_s;
         cs_h   <= cs_s;
      end
   end

   // core state
   state_t            state, state_n;
   logic [CW-1:0]     bit_cnt, bit_n;
   logic [DATA_W-1:0] rx_sh, rx_sh_n, rx_in;
   logic [DATA_W-1:0] tx_sh, tx_sh_n, tx_adv, tx_buf, tx_buf_n;
   logic [DATA_W-1:0] rx_data_n;
   logic              rx_valid_n, ferr_n;
   logic              tx_full, tx_full_n, xfer;
   // armed: CS has been seen high since reset, so a falling edge is real
   logic              armed, armed_n;

   assign rx_in  = LSB_FIRST ? {mosi_s, rx_sh[DATA_W-1:1]}
                             : {rx_sh[DATA_W-2:0], mosi_s};
   assign tx_adv = LSB_FIRST ? (tx_sh >> 1) : (tx_sh << 1);

   assign MISO     = (state == ACTIVE) &
                     (LSB_FIRST ? tx_sh[0] : tx_sh[DATA_W-1]);
   assign tx_ready = ~tx_full;

   always_comb begin
      state_n    = state;
      bit_n      = bit_cnt;
      rx_sh_n    = rx_sh;
      tx_sh_n    = tx_sh;
      rx_data_n  = rx_data;
      rx_valid_n = 1'b0;
      ferr_n     = 1'b0;
      xfer       = 1'b0;
      armed_n    = armed | (ok_s & cs_s);
      unique case (state)
         IDLE: begin
            if (cs_fall && armed) begin
               state_n = ACTIVE;
               bit_n   = '0;
               rx_sh_n = '0;
               tx_sh_n = tx_full ? tx_buf : '0;
               xfer    = tx_full;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               state_n = IDLE;
               bit_n   = '0;
               ferr_n  = (bit_cnt != '0);
            end else if (sclk_rise) begin
               rx_sh_n = rx_in;
               if (bit_cnt == CW'(DATA_W - 1)) begin
                  rx_data_n  = rx_in;
                  rx_valid_n = 1'b1;
                  bit_n      = '0;
               end else begin
                  bit_n = bit_cnt + CW'(1);
               end
            end else if (sclk_fall) begin
               // a falling edge at count 0 ends a word: fetch the next one
               if (bit_cnt == '0) begin
                  tx_sh_n = tx_full ? tx_buf : '0;
                  xfer    = tx_full;
               end else begin
                  tx_sh_n = tx_adv;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // a load in the same cycle as a transfer refills the emptied buffer
   always_comb begin
      tx_buf_n  = tx_buf;
      tx_full_n = tx_full & ~xfer;
      if (tx_load && (!tx_full || xfer)) begin
         tx_buf_n  = tx_data;
         tx_full_n = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         rx_sh     <= '0;
         tx_sh     <= '0;
         tx_buf    <= '0;
         tx_full   <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         armed     <= 1'b0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_n;
         rx_sh     <= rx_sh_n;
         tx_sh     <= tx_sh_n;
         tx_buf    <= tx_buf_n;
         tx_full   <= tx_full_n;
         rx_data   <= rx_data_n;
         rx_valid  <= rx_valid_n;
         frame_err <= ferr_n;
         armed     <= armed_n;
      end
   end

endmodule
